// File: rtl/hist_pkg.sv
// ---------------------------------------------------------------------------
// hist_pkg -- shared definitions for the histogram controller.
//   AW        : bin address width (ADC code width)
//   DEPTH     : number of histogram bins
//   N_DEFAULT : default bin width (RAM data width)
//   state_e   : controller state encoding
//   sat_inc   : saturating 32-bit increment for the sample counter
// ---------------------------------------------------------------------------
package hist_pkg;

    localparam int AW        = 10;
    localparam int DEPTH     = 1024;
    localparam int N_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACQ,
        RD_ISSUE,
        RD_WAIT,
        RD_PRESENT,
        DONE
    } state_e;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hist_addr_cnt.sv
// ---------------------------------------------------------------------------
// hist_addr_cnt -- clearable up-counter with terminal-count flag. Walks the
// bin addresses for both the RAM clear sweep and the readout sweep.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (wins over en_i)
//   en_i       : advance by one
//   cnt_o      : current count
//   tc_o       : high while cnt_o == LAST
// ---------------------------------------------------------------------------
module hist_addr_cnt
    import hist_pkg::*;
#(
    parameter int WIDTH = AW,
    parameter int LAST  = DEPTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d; no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == WIDTH'(LAST));

endmodule

// File: rtl/hist_ctrl.sv
// ---------------------------------------------------------------------------
// hist_ctrl -- histogram acquisition controller.
// Clears the external histogram RAM, turns ADC sample strobes into
// increment requests, then streams every bin out over a valid/ready port.
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, stop             : run control pulses
//   count_limit             : samples to accumulate (0 = until stop)
//   sample_valid, sample    : ADC strobe and code (code = bin address)
//   ram_we, ram_clr,
//   ram_addr                : RAM increment / write-zero port
//   rd_addr, rd_data        : RAM read port (data one cycle after address)
//   out_valid, out_data,
//   out_last, out_ready     : readout stream, out_last on bin DEPTH-1
//   busy, done, samples_seen: status
// ---------------------------------------------------------------------------
module hist_ctrl
    import hist_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = hist_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   count_limit,
    input  logic          sample_valid,
    input  logic [AW-1:0] sample,
    output logic          ram_we,
    output logic          ram_clr,
    output logic [AW-1:0] ram_addr,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [31:0]   samples_seen
);

    state_e        state_q;
    logic          ram_we_q;
    logic          ram_clr_q;
    logic [AW-1:0] ram_addr_q;
    logic [AW-1:0] rd_addr_q;
    logic          out_valid_q;
    logic [N-1:0]  out_data_q;
    logic          out_last_q;
    logic          busy_q;
    logic          done_q;
    logic [31:0]   samples_seen_q;
    logic          stop_seen_q;

    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_inc;
    logic          cnt_tc;
    logic          cnt_clr;
    logic          cnt_en;
    logic          acq_end;

    // Shared bin counter: during CLEAR it tracks the address being zeroed,
    // during readout it tracks the bin k being presented.
    hist_addr_cnt #(
        .WIDTH (AW),
        .LAST  (DEPTH - 1)
    ) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE, DONE: cnt_clr = start;
            CLEAR:      cnt_en  = !cnt_tc;
            ACQ:        cnt_clr = 1'b1;  // readout begins at bin 0
            RD_PRESENT: cnt_en  = out_ready && !cnt_tc;
            default:    cnt_en  = 1'b0;
        endcase
    end

    // Exit is judged on registered state: the limit is seen in the same cycle
    // the final ram_we is on the bus, and a stop is remembered for one cycle so
    // a sample strobed alongside it is still written before leaving ACQ.
    assign acq_end = stop_seen_q ||
                     ((count_limit != 32'd0) && (samples_seen_q >= count_limit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ram_we_q       <= 1'b0;
            ram_clr_q      <= 1'b0;
            ram_addr_q     <= '0;
            rd_addr_q      <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            samples_seen_q <= '0;
            stop_seen_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q        <= CLEAR;
                        samples_seen_q <= '0;
                        done_q         <= 1'b0;
                        busy_q         <= 1'b1;
                        ram_clr_q      <= 1'b1;
                        ram_addr_q     <= '0;
                        stop_seen_q    <= 1'b0;
                    end
                end

                CLEAR: begin
                    if (cnt_tc) begin
                        state_q   <= ACQ;
                        ram_clr_q <= 1'b0;
                    end else begin
                        ram_addr_q <= cnt_inc;
                    end
                end

                ACQ: begin
                    if (acq_end) begin
                        state_q     <= RD_ISSUE;
                        ram_we_q    <= 1'b0;
                        rd_addr_q   <= '0;
                        stop_seen_q <= 1'b0;
                    end else begin
                        ram_we_q <= sample_valid;
                        if (sample_valid) begin
                            ram_addr_q     <= sample;
                            samples_seen_q <= sat_inc(samples_seen_q);
                        end
                        if (stop) begin
                            stop_seen_q <= 1'b1;
                        end
                    end
                end

                RD_ISSUE: begin
                    state_q <= RD_WAIT;
                end

                RD_WAIT: begin
                    out_data_q  <= rd_data;
                    out_valid_q <= 1'b1;
                    out_last_q  <= cnt_tc;
                    state_q     <= RD_PRESENT;
                end

                RD_PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (cnt_tc) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= RD_ISSUE;
                            rd_addr_q <= cnt_inc;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we       = ram_we_q;
    assign ram_clr      = ram_clr_q;
    assign ram_addr     = ram_addr_q;
    assign rd_addr      = rd_addr_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign samples_seen = samples_seen_q;

endmodule

// File: tb/tb_hist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hist_ctrl -- self-checking bench for hist_ctrl. A behavioural RAM
// (increment / clear / registered read) sits on the RAM ports, and a
// reference histogram is built from the samples the bench presents during
// acquisition. Readout beats are compared against that reference.
// ---------------------------------------------------------------------------
module tb_hist_ctrl;

    localparam int N     = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [31:0]   count_limit;
    logic          sample_valid;
    logic [AW-1:0] sample;
    logic          ram_we;
    logic          ram_clr;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [31:0]   samples_seen;

    int checks = 0;
    int errors = 0;

    int unsigned ref_hist [DEPTH];
    int unsigned exp_seen;
    logic        scramble;

    logic [N-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    hist_ctrl #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .count_limit  (count_limit),
        .sample_valid (sample_valid),
        .sample       (sample),
        .ram_we       (ram_we),
        .ram_clr      (ram_clr),
        .ram_addr     (ram_addr),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .samples_seen (samples_seen)
    );

    // Histogram RAM: starts full of garbage so the clear sweep matters.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= N'($urandom);
        end else begin
            if (ram_we)  mem[ram_addr] <= mem[ram_addr] + 1'b1;
            if (ram_clr) mem[ram_addr] <= '0;
        end
        rd_data <= mem[rd_addr];
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        checks++;
        if (ram_we === 1'b1 && ram_clr === 1'b1) begin
            errors++;
            $display("FAIL we_clr_exclusive got ram_we=1 ram_clr=1 expected never both");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; stop = 0; count_limit = 0;
        sample_valid = 0; sample = '0; out_ready = 0;
        scramble = 1'b1;
        @(posedge clk);
        #1 scramble = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ram_we, ram_clr, out_valid, out_last, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000000",
                     {ram_we, ram_clr, out_valid, out_last, busy, done});
        end
        checks++;
        if (ram_addr !== '0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr got ram_addr=%0d rd_addr=%0d expected 0", ram_addr, rd_addr);
        end
        checks++;
        if (out_data !== '0 || samples_seen !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got out_data=%0d samples_seen=%0d expected 0",
                     out_data, samples_seen);
        end
    endtask

    // Start a run; stray start/stop/sample_valid pulses mid-sweep must be ignored.
    task automatic run_clear(input logic [31:0] limit);
        count_limit = limit;
        foreach (ref_hist[i]) ref_hist[i] = 0;
        exp_seen = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || samples_seen !== 32'd0) begin
            errors++;
            $display("FAIL start_status got busy=%b done=%b seen=%0d expected 1 0 0",
                     busy, done, samples_seen);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (ram_clr !== 1'b1 || ram_addr !== AW'(i) || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL clear_sweep cycle %0d got clr=%b addr=%0d we=%b expected 1 %0d 0",
                         i, ram_clr, ram_addr, ram_we, i);
            end
            start        = (i == 500);
            stop         = (i == 700);
            sample_valid = 1'($urandom_range(0, 1));
            sample       = AW'($urandom);
            cycle();
        end
        start = 0; stop = 0; sample_valid = 0;
        checks++;
        if (ram_clr !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b1 || samples_seen !== 32'd0) begin
            errors++;
            $display("FAIL clear_end got clr=%b we=%b busy=%b seen=%0d expected 0 0 1 0",
                     ram_clr, ram_we, busy, samples_seen);
        end
    endtask

    // One ACQ cycle: strobe (or not) and observe the registered write one cycle later.
    task automatic acq_step(input logic v, input logic [AW-1:0] s);
        sample_valid = v;
        sample       = s;
        if (v) begin
            ref_hist[s]++;
            exp_seen++;
        end
        cycle();
        sample_valid = 1'b0;
        checks++;
        if (ram_we !== v || (v && ram_addr !== s) || samples_seen !== exp_seen) begin
            errors++;
            $display("FAIL acq_write got we=%b addr=%0d seen=%0d expected we=%b addr=%0d seen=%0d",
                     ram_we, ram_addr, samples_seen, v, s, exp_seen);
        end
    endtask

    task automatic expect_readout_entry(input string tag);
        cycle();
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b1 || rd_addr !== '0 || samples_seen !== exp_seen) begin
            errors++;
            $display("FAIL %s got we=%b busy=%b rd_addr=%0d seen=%0d expected 0 1 0 %0d",
                     tag, ram_we, busy, rd_addr, samples_seen, exp_seen);
        end
    endtask

    // mode 0: ready held high, 1: ready toggles every cycle, 2: random ready.
    task automatic run_readout(input int mode);
        int           k = 0;
        logic         held = 1'b0;
        logic [N-1:0] held_data = '0;
        logic         rdy;
        for (int cyc = 0; cyc < 20000 && k < DEPTH; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready    = rdy;
            start        = (cyc == 37);
            stop         = (cyc == 41);
            sample_valid = 1'($urandom_range(0, 1));
            sample       = AW'($urandom);
            if (out_valid === 1'b1) begin
                if (held) begin
                    checks++;
                    if (out_data !== held_data) begin
                        errors++;
                        $display("FAIL stall_hold bin %0d got %0d expected %0d", k, out_data, held_data);
                    end
                end
                if (rdy) begin
                    checks++;
                    if (out_data !== N'(ref_hist[k]) || out_last !== (k == DEPTH - 1)) begin
                        errors++;
                        $display("FAIL beat bin %0d got data=%0d last=%b expected data=%0d last=%b",
                                 k, out_data, out_last, ref_hist[k], (k == DEPTH - 1));
                    end
                    k++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = out_data;
                end
            end
            cycle();
        end
        out_ready = 0; start = 0; stop = 0; sample_valid = 0;
        checks++;
        if (k != DEPTH) begin
            errors++;
            $display("FAIL beat_count got %0d expected %0d", k, DEPTH);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || samples_seen !== exp_seen) begin
            errors++;
            $display("FAIL readout_done got done=%b busy=%b valid=%b seen=%0d expected 1 0 0 %0d",
                     done, busy, out_valid, samples_seen, exp_seen);
        end
        repeat (5) cycle();
        checks++;
        if (done !== 1'b1 || ram_we !== 1'b0 || ram_clr !== 1'b0) begin
            errors++;
            $display("FAIL done_hold got done=%b we=%b clr=%b expected 1 0 0", done, ram_we, ram_clr);
        end
    endtask

    task automatic test_limit_back_to_back();
        logic [AW-1:0] seq [5] = '{10'd3, 10'd3, 10'd7, 10'd1023, 10'd0};
        run_clear(32'd5);
        foreach (seq[i]) acq_step(1'b1, seq[i]);
        expect_readout_entry("limit_exit");
        run_readout(1);
    endtask

    task automatic test_stop_same_cycle();
        run_clear(32'd0);
        stop = 1'b1;
        acq_step(1'b1, AW'(12));
        stop = 1'b0;
        expect_readout_entry("stop_exit");
        run_readout(0);
    endtask

    task automatic test_random(input logic [31:0] limit);
        run_clear(limit);
        for (int c = 0; c < 5000 && exp_seen < limit; c++) begin
            if ($urandom_range(0, 3) != 0)
                acq_step(1'b1, ($urandom_range(0, 9) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 31)));
            else
                acq_step(1'b0, AW'($urandom));
        end
        expect_readout_entry("random_exit");
        run_readout(2);
    endtask

    task automatic test_reset_mid_acq();
        run_clear(32'd0);
        for (int i = 0; i < 100; i++) acq_step(1'b1, AW'($urandom_range(0, 63)));
        sample_valid = 1'b1;
        sample       = AW'(5);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_clr, out_valid, out_last, busy, done} !== 6'b0 ||
            ram_addr !== '0 || rd_addr !== '0 || out_data !== '0 || samples_seen !== 32'd0) begin
            errors++;
            $display("FAIL reset_async flags=%b addr=%0d rd=%0d data=%0d seen=%0d expected all 0",
                     {ram_we, ram_clr, out_valid, out_last, busy, done},
                     ram_addr, rd_addr, out_data, samples_seen);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample       = AW'($urandom);
            stop         = (i == 10);
            cycle();
            checks++;
            if (ram_we !== 1'b0 || ram_clr !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet cycle %0d got we=%b clr=%b busy=%b expected 0 0 0",
                         i, ram_we, ram_clr, busy);
            end
        end
        sample_valid = 0; stop = 0;
    endtask

    initial begin
        test_reset();
        test_limit_back_to_back();
        test_stop_same_cycle();
        test_random(32'($urandom_range(20, 60)));
        test_reset_mid_acq();
        test_random(32'($urandom_range(80, 150)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_ctrl.md
HIST_CTRL -- requirements
Module: hist_ctrl

Interface
REQ-001 Parameter N, default 16: histogram bin width in bits, equal to the RAM data width.
REQ-002 Parameter DEPTH, default 1024: number of bins; address width AW = 10.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins clear, then acquisition; honoured only in IDLE or DONE.
REQ-006 stop  in  1  one-cycle pulse; ends acquisition early; honoured only in ACQ.
REQ-007 count_limit  in  32  number of samples to accumulate; 0 means unlimited (stop only).
REQ-008 sample_valid  in  1  ADC sample strobe.
REQ-009 sample  in  AW  ADC code, used as the bin address.
REQ-010 ram_we  out  1  increment-enable to the histogram RAM.
REQ-011 ram_clr  out  1  write-zero enable to the histogram RAM.
REQ-012 ram_addr  out  AW  bin address for increment or clear.
REQ-013 rd_addr  out  AW  RAM read-port address.
REQ-014 rd_data  in  N  RAM read-port data, valid one cycle after rd_addr.
REQ-015 out_valid, out_data[N-1:0], out_last  out  readout stream; out_last marks bin DEPTH-1.
REQ-016 out_ready  in  1  readout stream backpressure.
REQ-017 busy, done  out  1  status; samples_seen[31:0] out: accumulated sample count.

Function
REQ-018 States: IDLE, CLEAR, ACQ, RD_ISSUE, RD_WAIT, RD_PRESENT, DONE.
REQ-019 IDLE/DONE + start -> CLEAR; samples_seen <= 0; done <= 0.
REQ-020 CLEAR: ram_clr=1, ram_addr sweeps 0..DEPTH-1 at one address per cycle; exactly DEPTH cycles, then -> ACQ.
REQ-021 ACQ: sample_valid in cycle t gives ram_we=1 and ram_addr=sample in cycle t+1 (registered); samples_seen increments in t+1.
REQ-022 Back-to-back sample_valid is accepted every cycle, with no drops.
REQ-023 ACQ -> RD_ISSUE when samples_seen reaches a nonzero count_limit, or on stop; the exit takes effect only after the final ram_we cycle has been issued.
REQ-024 A sample_valid in the same cycle as stop is counted and written; sample_valid in any state other than ACQ is ignored.
REQ-025 Readout: RD_ISSUE drives rd_addr=k -> RD_WAIT -> RD_PRESENT, where out_data=rd_data (captured), out_valid=1, held stable until out_ready.
REQ-026 out_valid & out_ready at k<DEPTH-1 -> RD_ISSUE with k+1; at k=DEPTH-1 (out_last=1) -> DONE.
REQ-027 DONE: done=1 until the next start; busy=1 in every state except IDLE and DONE.
REQ-028 samples_seen saturates at 2^32-1 and does not wrap.
REQ-029 ram_we and ram_clr are never asserted together; both are 0 outside ACQ and CLEAR respectively.
REQ-030 start while busy is ignored; stop outside ACQ is ignored.

Reset
REQ-031 On rst_n low, all state clears asynchronously: state=IDLE; ram_we, ram_clr, out_valid, out_last, busy, done = 0; ram_addr, rd_addr, out_data, samples_seen = 0.
REQ-032 Reset in the middle of any operation abandons it; after rst_n rises, no RAM write occurs until a new start.

Structure
REQ-033 The shared package hist_pkg holds the state enum, AW, DEPTH and the default N.
REQ-034 A single sub-module, hist_addr_cnt, is used by both CLEAR and readout: a clearable AW-bit up-counter with a terminal-count flag.

Verification
REQ-035 start, with DEPTH=1024 -> ram_clr high for exactly 1024 cycles, addresses 0..1023 in order, then ACQ.
REQ-036 count_limit=5, samples 3,3,7,1023,0 back-to-back -> five ram_we pulses, each one cycle after its strobe, with addresses 3,3,7,1023,0; then readout starts.
REQ-037 count_limit=0, stop in the same cycle as sample_valid=12 -> sample written, samples_seen=1, readout starts.
REQ-038 Readout with out_ready toggling 1/0 every cycle -> 1024 beats, data stable while stalled, out_last only on the final beat, then done=1.
REQ-039 rst_n low during ACQ at samples_seen=100 -> all outputs 0 immediately; no ram_we after release until start.
REQ-040 start pulsed during CLEAR and during readout -> ignored; the sequence and the beat count are unchanged.
